// File: rtl/logic_unit_sched.sv
// logic_unit_sched
//   Round-robin scheduler in front of one shared 1-bit function-table logic
//   unit (out = func[{a,b}]). A granted request is evaluated bit-serially,
//   LSB first, over WIDTH cycles. The WIDTH-bit result is then returned with
//   a single-cycle done pulse.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       per-requester request, held until the requester's gnt bit
//   req_func  4-bit function code per requester, slice i = [4i+3:4i]
//   req_a     operand A per requester, slice i = [WIDTH*i +: WIDTH]
//   req_b     operand B per requester, same slicing
//   gnt       one-hot acceptance pulse, first RUN cycle only
//   busy      high whenever the FSM is not IDLE
//   done      single-cycle result-valid pulse
//   done_id   requester index for the word on result
//   result    result word, held until the next done
//
// state | meaning
// IDLE  | waiting; req sampled here only, winner captured on the edge
// RUN   | one result bit per cycle, counter 0..WIDTH-1; gnt in first cycle
// DONE  | done pulse; result/done_id already updated on entry
module logic_unit_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [4*N_REQ-1:0]     req_func,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [WIDTH-1:0]       result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [3:0]         func_q, func_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [ID_W-1:0]    done_id_q, done_id_d;

  // Winner search: duplicate req and shift by the pointer so that bit k of
  // the shifted vector is requester (ptr+k) mod N_REQ.
  logic [2*N_REQ-1:0] req_rot;
  logic               win_found;
  logic [ID_W-1:0]    win_id;

  always_comb begin
    req_rot   = {req, req} >> ptr_q;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  // Operand mux for the winning requester.
  logic [3:0]       sel_func;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  always_comb begin
    sel_func = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == win_id) begin
        sel_func = req_func[4*i +: 4];
        sel_a    = req_a[WIDTH*i +: WIDTH];
        sel_b    = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  logic lu_bit;
  assign lu_bit = func_q[{a_q[cnt_q], b_q[cnt_q]}];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      func_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      func_q    <= func_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    func_d    = func_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    done_id_d = done_id_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          func_d  = sel_func;
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = win_id;
          ptr_d   = ID_W'((int'(win_id) + 1) % N_REQ);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[cnt_q] = lu_bit;
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Publish on entry to DONE so result/done_id are valid with done
          // and untouched while the next operation runs.
          result_d  = acc_d;
          done_id_d = id_q;
          cnt_d     = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    gnt  = '0;
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    if (state_q == RUN && cnt_q == '0) begin
      gnt[id_q] = 1'b1;
    end
  end

  assign done_id = done_id_q;
  assign result  = result_q;

endmodule

// File: tb/tb_logic_unit_sched.sv
module tb_logic_unit_sched;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int ID_W  = 2;

  logic                   clk;
  logic                   rst_n;
  logic [N_REQ-1:0]       req;
  logic [4*N_REQ-1:0]     req_func;
  logic [WIDTH*N_REQ-1:0] req_a;
  logic [WIDTH*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [WIDTH-1:0]       result;

  logic [3:0]       func_v [N_REQ];
  logic [WIDTH-1:0] a_v    [N_REQ];
  logic [WIDTH-1:0] b_v    [N_REQ];
  logic [N_REQ-1:0] req_v;

  int n_checks = 0;
  int n_errors = 0;

  logic_unit_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_func (req_func),
    .req_a    (req_a),
    .req_b    (req_b),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .result   (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    req = req_v;
    for (int i = 0; i < N_REQ; i++) begin
      req_func[4*i +: 4]     = func_v[i];
      req_a[WIDTH*i +: WIDTH] = a_v[i];
      req_b[WIDTH*i +: WIDTH] = b_v[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] lu_word(input logic [3:0] f,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = f[2*a[i] + b[i]];
    return r;
  endfunction

  // Reference model and scoreboard: expected results are pushed at the
  // capture edge, popped when the DUT signals done.
  typedef struct {
    int               id;
    logic [WIDTH-1:0] res;
  } sb_t;
  sb_t sb[$];

  int m_state;   // 0 idle, 1 run, 2 done
  int m_cnt;
  int m_ptr;
  int m_id;

  always @(posedge clk or negedge rst_n) begin : model
    int  w;
    bit  found;
    sb_t e;
    if (!rst_n) begin
      m_state <= 0;
      m_cnt   <= 0;
      m_ptr   <= 0;
      m_id    <= 0;
      sb.delete();
    end else begin
      case (m_state)
        0: begin
          found = 1'b0;
          w = 0;
          for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_v[(m_ptr + k) % N_REQ]) begin
              found = 1'b1;
              w = (m_ptr + k) % N_REQ;
            end
          end
          if (found) begin
            e.id  = w;
            e.res = lu_word(func_v[w], a_v[w], b_v[w]);
            sb.push_back(e);
            m_id    <= w;
            m_ptr   <= (w + 1) % N_REQ;
            m_cnt   <= 0;
            m_state <= 1;
          end
        end
        1: begin
          if (m_cnt == WIDTH - 1) m_state <= 2;
          m_cnt <= m_cnt + 1;
        end
        default: m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    logic [N_REQ-1:0] exp_gnt;
    sb_t e;
    if (rst_n) begin
      exp_gnt = '0;
      if (m_state == 1 && m_cnt == 0) exp_gnt[m_id] = 1'b1;
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("done", 32'(done), 32'(m_state == 2));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("sb_done_id", 32'(done_id), 32'(e.id));
          chk("sb_result", 32'(result), 32'(e.res));
        end
      end
    end
  end

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    int r = -1;
    for (int i = 0; i < N_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_op(input int id, input logic [3:0] f,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    func_v[id] = f;
    a_v[id]    = a;
    b_v[id]    = b;
    req_v[id]  = 1'b1;
  endtask

  // Waits for this requester's grant, drops its req, then waits for done and
  // checks latency, result and id.
  task automatic finish_op(input int id, input logic [WIDTH-1:0] exp_res, input bit scramble);
    int n = 0;
    while (gnt[id] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("gnt_seen", 32'(gnt[id] === 1'b1), 32'd1);
    chk("gnt_onehot", 32'(gnt), 32'(1 << id));
    req_v[id] = 1'b0;
    n = 0;
    @(negedge clk);
    n++;
    if (scramble) begin
      func_v[id] = ~func_v[id];
      a_v[id]    = ~a_v[id];
      b_v[id]    = ~b_v[id];
    end
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", 32'(n), 32'(WIDTH));
    chk("op_result", 32'(result), 32'(exp_res));
    chk("op_done_id", 32'(done_id), 32'(id));
  endtask

  task automatic do_op(input int id, input logic [3:0] f, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_res,
                       input bit scramble);
    @(negedge clk);
    start_op(id, f, a, b);
    finish_op(id, exp_res, scramble);
  endtask

  int g_id  [8];
  int g_cyc [8];

  task automatic run_grants(input int n, input bit keep);
    int cyc = 0;
    int got = 0;
    int id;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        id = onehot_idx(gnt);
        g_id[got]  = id;
        g_cyc[got] = cyc;
        got++;
        if (keep) begin
          func_v[id] = 4'($urandom);
          a_v[id]    = WIDTH'($urandom);
          b_v[id]    = WIDTH'($urandom);
        end else begin
          req_v[id] = 1'b0;
        end
      end
    end
    chk("grant_count", 32'(got), 32'(n));
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_rr [6];
    exp_rr = '{0, 1, 3, 0, 1, 3};
    rst_n = 1'b0;
    req_v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      func_v[i] = '0;
      a_v[i]    = '0;
      b_v[i]    = '0;
    end
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed functions
    do_op(0, 4'b1000, 8'hF0, 8'hCC, 8'hC0, 1'b0);
    do_op(2, 4'b0110, 8'hA5, 8'hFF, 8'h5A, 1'b0);
    do_op(2, 4'b1110, 8'h0F, 8'h30, 8'h3F, 1'b0);
    do_op(2, 4'b0001, 8'h0F, 8'h30, 8'hC0, 1'b0);

    // Continuous requests on 0, 1, 3 from a fresh pointer
    do_reset();
    @(negedge clk);
    start_op(0, 4'b1000, 8'h12, 8'h34);
    start_op(1, 4'b0110, 8'h56, 8'h78);
    start_op(3, 4'b1110, 8'h9A, 8'hBC);
    run_grants(6, 1'b1);
    req_v = '0;
    for (int k = 0; k < 6; k++) chk("rr_order", 32'(g_id[k]), 32'(exp_rr[k]));
    for (int k = 1; k < 6; k++) chk("rr_spacing", 32'(g_cyc[k] - g_cyc[k-1]), 32'(WIDTH + 2));
    repeat (12) @(negedge clk);

    // All four at once after reset
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++)
      start_op(i, 4'($urandom), WIDTH'($urandom), WIDTH'($urandom));
    run_grants(4, 1'b0);
    for (int k = 0; k < 4; k++) chk("all4_order", 32'(g_id[k]), 32'(k));
    repeat (12) @(negedge clk);

    // Reset in the 4th RUN cycle aborts the operation
    @(negedge clk);
    start_op(0, 4'b0110, 8'h3C, 8'h0F);
    begin
      int n = 0;
      while (gnt[0] !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("abort_gnt", 32'(gnt), 32'd1);
    end
    req_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_gnt0", 32'(gnt), 32'd0);
    chk("abort_busy0", 32'(busy), 32'd0);
    chk("abort_done0", 32'(done), 32'd0);
    chk("abort_done_id0", 32'(done_id), 32'd0);
    chk("abort_result0", 32'(result), 32'd0);
    start_op(1, 4'b1000, 8'hFF, 8'h3C);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    finish_op(1, 8'h3C, 1'b0);

    // Constant functions and operand changes after grant
    do_op(0, 4'b0000, 8'h5A, 8'hC3, 8'h00, 1'b0);
    do_op(0, 4'b1111, 8'h5A, 8'hC3, 8'hFF, 1'b1);
    do_op(3, 4'b1000, 8'h5A, 8'hC3, 8'h42, 1'b1);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
